// File: rtl/ahb_read_sel_ctrl.sv
// Address decoder and data-phase select sequencer for a three-slave AHB-Lite read path,
// including the default slave that answers unmapped accesses with a two-cycle ERROR.
module ahb_read_sel_ctrl #(
  parameter int DEC_HI = 31,
  parameter int DEC_LO = 30,
  parameter int CNT_W  = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [31:0]      HADDR,
  input  logic [1:0]       HTRANS,
  input  logic             HREADY,
  input  logic             HREADYOUT_1,
  input  logic             HREADYOUT_2,
  input  logic             HREADYOUT_3,
  input  logic             HRESP_1,
  input  logic             HRESP_2,
  input  logic             HRESP_3,
  output logic             HSEL_1,
  output logic             HSEL_2,
  output logic             HSEL_3,
  output logic [1:0]       SEL,
  output logic             HREADY_OUT,
  output logic             HRESP,
  output logic [CNT_W-1:0] ERR_CNT
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic             dp_active_q, dp_active_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       region_s;
  logic             err_start_s;
  logic             fsm_ready_s;
  logic             fsm_resp_s;
  logic             unused_haddr_s;

  assign region_s       = HADDR[DEC_HI:DEC_LO];
  assign err_start_s    = HREADY & HTRANS[1] & (region_s == 2'b11);
  assign unused_haddr_s = ^{HADDR, HTRANS[0]};

  // Selects are gated by reset so nothing is selected while the bus is held in reset.
  assign HSEL_1 = RST & HTRANS[1] & (region_s == 2'b00);
  assign HSEL_2 = RST & HTRANS[1] & (region_s == 2'b01);
  assign HSEL_3 = RST & HTRANS[1] & (region_s == 2'b10);

  // Next-state logic: data-phase capture and default-slave sequencing.
  always_comb begin
    sel_d       = sel_q;
    dp_active_d = dp_active_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    if (HREADY) begin
      sel_d       = region_s;
      dp_active_d = HTRANS[1];
    end else begin
      sel_d       = sel_q;
      dp_active_d = dp_active_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (err_start_s) state_d = ST_ERR1;
        else             state_d = ST_IDLE;
      end
      ST_ERR1: begin
        state_d = ST_ERR2;
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
        else                  cnt_d = cnt_q;
      end
      ST_ERR2: begin
        if (err_start_s) state_d = ST_ERR1;
        else             state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sel_q       <= 2'b00;
      dp_active_q <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
    end else begin
      sel_q       <= sel_d;
      dp_active_q <= dp_active_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
    end
  end

  // Default-slave response per FSM state.
  always_comb begin
    fsm_ready_s = 1'b1;
    fsm_resp_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin fsm_ready_s = 1'b1; fsm_resp_s = 1'b0; end
      ST_ERR1: begin fsm_ready_s = 1'b0; fsm_resp_s = 1'b1; end
      ST_ERR2: begin fsm_ready_s = 1'b1; fsm_resp_s = 1'b1; end
      default: begin fsm_ready_s = 1'b1; fsm_resp_s = 1'b0; end
    endcase
  end

  // Response mux back to the master; no active data phase means zero-wait OKAY.
  always_comb begin
    HREADY_OUT = 1'b1;
    HRESP      = 1'b0;
    if (!dp_active_q) begin
      HREADY_OUT = 1'b1;
      HRESP      = 1'b0;
    end else begin
      case (sel_q)
        2'b00:   begin HREADY_OUT = HREADYOUT_1; HRESP = HRESP_1;    end
        2'b01:   begin HREADY_OUT = HREADYOUT_2; HRESP = HRESP_2;    end
        2'b10:   begin HREADY_OUT = HREADYOUT_3; HRESP = HRESP_3;    end
        default: begin HREADY_OUT = fsm_ready_s; HRESP = fsm_resp_s; end
      endcase
    end
  end

  assign SEL     = sel_q;
  assign ERR_CNT = cnt_q;

endmodule

// File: tb/tb_ahb_read_sel_ctrl.sv
// Directed self-checking bench for ahb_read_sel_ctrl; HREADY is looped back from HREADY_OUT.
module tb_ahb_read_sel_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hready;
  logic        hro1, hro2, hro3;
  logic        hrs1, hrs2, hrs3;
  logic        hsel1, hsel2, hsel3;
  logic [1:0]  sel;
  logic        hready_out;
  logic        hresp;
  logic [7:0]  err_cnt;

  int checks_cnt = 0;
  int fail_cnt   = 0;

  assign hready = hready_out;

  ahb_read_sel_ctrl dut (
    .CLK(clk), .RST(rst), .HADDR(haddr), .HTRANS(htrans), .HREADY(hready),
    .HREADYOUT_1(hro1), .HREADYOUT_2(hro2), .HREADYOUT_3(hro3),
    .HRESP_1(hrs1), .HRESP_2(hrs2), .HRESP_3(hrs3),
    .HSEL_1(hsel1), .HSEL_2(hsel2), .HSEL_3(hsel3),
    .SEL(sel), .HREADY_OUT(hready_out), .HRESP(hresp), .ERR_CNT(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit found;
    rst    = 1'b0;
    haddr  = 32'hC000_0000;
    htrans = 2'b10;
    {hro1, hro2, hro3} = 3'b111;
    {hrs1, hrs2, hrs3} = 3'b000;

    // 1. reset state
    #7;
    check("rst_hsel", {29'd0, hsel3, hsel2, hsel1}, 32'd0);
    check("rst_sel", {30'd0, sel}, 32'd0);
    check("rst_rdy", {31'd0, hready_out}, 32'd1);
    check("rst_resp", {31'd0, hresp}, 32'd0);
    check("rst_cnt", {24'd0, err_cnt}, 32'd0);
    rst = 1'b1;
    #1;

    // 2. sequential reads to three slaves
    haddr = 32'h0000_0010; htrans = 2'b10; #1;
    check("dec1", {29'd0, hsel3, hsel2, hsel1}, 32'd1);
    step();
    check("sel1", {30'd0, sel}, 32'd0);
    haddr = 32'h4000_0020; #1;
    check("dec2", {29'd0, hsel3, hsel2, hsel1}, 32'd2);
    step();
    check("sel2", {30'd0, sel}, 32'd1);
    check("rdy2", {31'd0, hready_out}, 32'd1);
    haddr = 32'h8000_0030; #1;
    check("dec3", {29'd0, hsel3, hsel2, hsel1}, 32'd4);
    step();
    check("sel3", {30'd0, sel}, 32'd2);
    hrs3 = 1'b1; #1;
    check("resp3", {31'd0, hresp}, 32'd1);
    hrs3 = 1'b0;
    htrans = 2'b00;
    step();

    // 3. wait states from slave 2
    haddr = 32'h4000_0000; htrans = 2'b10;
    step();
    hro2 = 1'b0; haddr = 32'h8000_0000; #1;
    check("ws_sel_a", {30'd0, sel}, 32'd1);
    check("ws_rdy_a", {31'd0, hready_out}, 32'd0);
    step();
    check("ws_sel_b", {30'd0, sel}, 32'd1);
    check("ws_rdy_b", {31'd0, hready_out}, 32'd0);
    step();
    check("ws_sel_c", {30'd0, sel}, 32'd1);
    check("ws_rdy_c", {31'd0, hready_out}, 32'd0);
    hro2 = 1'b1; #1;
    check("ws_sel_d", {30'd0, sel}, 32'd1);
    check("ws_rdy_d", {31'd0, hready_out}, 32'd1);
    step();
    check("ws_sel_e", {30'd0, sel}, 32'd2);
    htrans = 2'b00;
    step();

    // 4. default slave error and back-to-back unmapped access
    haddr = 32'hC000_0004; htrans = 2'b10; #1;
    check("dec_unm", {29'd0, hsel3, hsel2, hsel1}, 32'd0);
    step();
    check("e1_sel", {30'd0, sel}, 32'd3);
    check("e1_rdy", {31'd0, hready_out}, 32'd0);
    check("e1_resp", {31'd0, hresp}, 32'd1);
    haddr = 32'hC000_0008; htrans = 2'b11;
    step();
    check("e2_rdy", {31'd0, hready_out}, 32'd1);
    check("e2_resp", {31'd0, hresp}, 32'd1);
    check("e2_cnt", {24'd0, err_cnt}, 32'd1);
    step();
    check("e3_rdy", {31'd0, hready_out}, 32'd0);
    check("e3_resp", {31'd0, hresp}, 32'd1);
    htrans = 2'b00;
    step();
    check("e4_rdy", {31'd0, hready_out}, 32'd1);
    check("e4_resp", {31'd0, hresp}, 32'd1);
    check("e4_cnt", {24'd0, err_cnt}, 32'd2);
    step();
    check("e5_rdy", {31'd0, hready_out}, 32'd1);
    check("e5_resp", {31'd0, hresp}, 32'd0);

    // 5. IDLE and BUSY to unmapped region
    haddr = 32'hC000_0000; htrans = 2'b00;
    step();
    check("idle_rdy", {31'd0, hready_out}, 32'd1);
    check("idle_resp", {31'd0, hresp}, 32'd0);
    htrans = 2'b01;
    step();
    check("busy_rdy", {31'd0, hready_out}, 32'd1);
    check("busy_resp", {31'd0, hresp}, 32'd0);
    check("busy_cnt", {24'd0, err_cnt}, 32'd2);
    check("busy_hsel", {29'd0, hsel3, hsel2, hsel1}, 32'd0);

    // 6. saturation, then asynchronous reset during ERR1
    htrans = 2'b10;
    for (int i = 0; i < 600; i++) step();
    check("sat_cnt", {24'd0, err_cnt}, 32'd255);
    found = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      if (hready_out == 1'b0) found = 1'b1;
      else step();
    end
    check("find_err1", {31'd0, found}, 32'd1);
    rst = 1'b0; #1;
    check("arst_rdy", {31'd0, hready_out}, 32'd1);
    check("arst_resp", {31'd0, hresp}, 32'd0);
    check("arst_cnt", {24'd0, err_cnt}, 32'd0);
    check("arst_hsel", {29'd0, hsel3, hsel2, hsel1}, 32'd0);
    htrans = 2'b00;
    step();
    rst = 1'b1;
    step();
    check("post_rdy", {31'd0, hready_out}, 32'd1);
    check("post_cnt", {24'd0, err_cnt}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
